note_scroller: RTL and testbench
================================

NOTE_SCROLLER -- requirements
Module: note_scroller

Interface
REQ-001 Parameter TICK_DIV, default 833333: CLOCK_50 cycles per scroll tick (60 Hz).
REQ-002 Parameter NOTES_PER_GAME, default 64: notes retired before game ends.
REQ-003 Parameter MAX_MISS, default 8: misses that end the game early.
REQ-004 Parameter SEED, default 16'hACE1: LFSR reset value, SHALL be nonzero.
REQ-005 CLOCK_50  in  1  sole clock, all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle pulse, begins or restarts a game.
REQ-008 hit  in  1  single-cycle pulse from hit detector, correct key pressed.
REQ-009 xoffset  out  9  pixel scroll offset for note sprites, range 0..47.
REQ-010 drawstream  out  25  five 5-bit sprite codes, slot 0 in [4:0], slot 4 in [24:20].
REQ-011 target  out  2  lane of slot-0 note, for hit detector.
REQ-012 score  out  8  hits this game.
REQ-013 misses  out  4  notes retired unhit this game.
REQ-014 done  out  1  high while game over.

Function
REQ-015 States IDLE, RUN, OVER; reset -> IDLE.
REQ-016 IDLE: start -> RUN; clears score, misses, retired count, slots; xoffset=47; divider=0.
REQ-017 RUN: divider counts 0..TICK_DIV-1; at TICK_DIV-1 wraps to 0 and issues one tick.
REQ-018 Tick with xoffset>0: xoffset decrements by 1.
REQ-019 Tick with xoffset==0: xoffset reloads 47 and a shift occurs in the same cycle.
REQ-020 Shift: slot i <= slot i+1 for i=0..3; slot 4 <= {3'b010, lfsr[1:0]}; LFSR advances one step.
REQ-021 LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances only on shift.
REQ-022 Sprite code 5'd0 = empty slot; nonzero = note, lane = code[1:0].
REQ-023 target = slot0[1:0]; 2'b00 when slot 0 empty.
REQ-024 Per-note armed flag set on each shift, cleared when a hit is accepted.
REQ-025 hit accepted only in RUN, slot 0 nonempty, armed set; score increments, saturating at 255.
REQ-026 hit otherwise ignored; at most one score per note.
REQ-027 Shift with outgoing slot 0 nonempty: retired count +1; misses +1 if armed still set.
REQ-028 hit and shift same cycle: hit applies to outgoing note (scores, not a miss); new slot 0 armed.
REQ-029 misses saturates at 15.
REQ-030 RUN -> OVER the cycle after retired==NOTES_PER_GAME or misses==MAX_MISS; OVER has priority over further shifts.
REQ-031 OVER: done=1; xoffset, slots, score, misses frozen; start -> RUN with REQ-016 clearing.
REQ-032 start during RUN ignored.
REQ-033 Output latency: all outputs registered, update the cycle after the causing event.

Reset
REQ-034 reset overrides all inputs: state IDLE, xoffset=47, drawstream=0, target=0, score=0, misses=0, done=0, divider=0, LFSR=SEED.
REQ-035 reset mid-RUN or mid-OVER returns to IDLE within one cycle; no partial score retained.

Structure
REQ-036 Shared package holds state encoding, sprite-code constants (EMPTY, NOTE_BASE=3'b010), SLOT_PITCH=48.
REQ-037 One sub-module natural: note_lfsr (SEED param, advance enable, 16-bit state out).

Verification (TICK_DIV=2, NOTES_PER_GAME=4, MAX_MISS=2)
REQ-038 reset then start -> xoffset 47; after 2 cycles 46; after 96 cycles first shift, slot 4 = {3'b010, lane from SEED}.
REQ-039 hit pulse with slot 0 holding note, armed -> score 1; second hit same note -> score stays 1.
REQ-040 hit coincident with shift cycle -> score +1, misses unchanged, new slot 0 armed.
REQ-041 no hits, two nonempty notes retired -> misses=2, done=1 next cycle, xoffset frozen.
REQ-042 score at 255 plus accepted hit -> score stays 255.
REQ-043 reset asserted mid-RUN with score 3 -> next cycle score 0, done 0, xoffset 47, state IDLE.

Source files
------------

// File: rtl/note_scroller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : note_scroller_pkg
//  Purpose  : Shared definitions for the note scroller. Holds the game state
//             encoding, the sprite-code constants and the slot pitch.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package note_scroller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  // Sprite code 0 marks an empty slot; notes are {NOTE_BASE, lane}.
  localparam logic [4:0] EMPTY      = 5'd0;
  localparam logic [2:0] NOTE_BASE  = 3'b010;

  // Horizontal distance in pixels between neighbouring note slots.
  localparam int         SLOT_PITCH = 48;
  localparam logic [8:0] XOFF_MAX   = 9'(SLOT_PITCH - 1);

  function automatic logic [4:0] note_code(input logic [1:0] lane);
    return {NOTE_BASE, lane};
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_scroller_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : note_lfsr
//  Purpose  : 16-bit Fibonacci LFSR (taps 16,14,13,11) used to pick the lane
//             of each new note. Steps only when advance is high.
//  Ports    : CLOCK_50  in   clock
//             reset     in   synchronous active-high reset, loads SEED
//             advance   in   step the register by one position
//             state     out  current 16-bit register contents
//  Revision : 1.0  initial release
// ============================================================================
module note_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;
  logic        feedback;

  // Bits 15,13,12,10 correspond to taps 16,14,13,11; feedback enters at bit 0.
  always_comb begin
    feedback = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];
    state_d  = state_q;
    if (advance) begin
      state_d = {state_q[14:0], feedback};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/note_scroller.sv
`default_nettype none
// ============================================================================
//  Module   : note_scroller
//  Purpose  : Rhythm-game note conveyor. Scrolls five note slots leftwards at
//             the tick rate, spawns random-lane notes at slot 4, scores hits on
//             the slot-0 note and counts notes that leave unhit as misses.
//  Ports    : CLOCK_50    in   clock
//             reset       in   synchronous active-high reset
//             start       in   pulse, begins/restarts a game from IDLE/OVER
//             hit         in   pulse, correct key for the slot-0 note
//             xoffset     out  pixel scroll offset 0..47
//             drawstream  out  five 5-bit sprite codes, slot 0 in [4:0]
//             target      out  lane of the slot-0 note
//             score       out  hits this game (saturates at 255)
//             misses      out  unhit retired notes (saturates at 15)
//             done        out  high while the game is over
//  Revision : 1.0  initial release
// ============================================================================
module note_scroller
  import note_scroller_pkg::*;
#(
  parameter int          TICK_DIV       = 833333,
  parameter int          NOTES_PER_GAME = 64,
  parameter int          MAX_MISS       = 8,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic        hit,
  output logic [8:0]  xoffset,
  output logic [24:0] drawstream,
  output logic [1:0]  target,
  output logic [7:0]  score,
  output logic [3:0]  misses,
  output logic        done
);

  localparam int             DW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int             RW          = $clog2(NOTES_PER_GAME + 1);
  localparam logic [DW-1:0]  DIV_LAST    = DW'(TICK_DIV - 1);
  localparam logic [RW-1:0]  RETIRE_END  = RW'(NOTES_PER_GAME);
  localparam logic [3:0]     MISS_END    = 4'(MAX_MISS);

  state_e        state_q,   state_d;
  logic [DW-1:0] div_q,     div_d;
  logic [8:0]    xoff_q,    xoff_d;
  logic [24:0]   slots_q,   slots_d;
  logic          armed_q,   armed_d;
  logic [7:0]    score_q,   score_d;
  logic [3:0]    misses_q,  misses_d;
  logic [RW-1:0] retired_q, retired_d;
  logic          done_q,    done_d;

  logic          tick;
  logic          shift;
  logic          hit_ok;
  logic [15:0]   lfsr_state;
  logic [13:0]   lfsr_unused;

  assign lfsr_unused = lfsr_state[15:2];

  note_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .advance (shift),
    .state   (lfsr_state)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    xoff_d    = xoff_q;
    slots_d   = slots_q;
    armed_d   = armed_q;
    score_d   = score_q;
    misses_d  = misses_q;
    retired_d = retired_q;
    tick      = 1'b0;
    shift     = 1'b0;
    hit_ok    = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d   = ST_RUN;
          div_d     = '0;
          xoff_d    = XOFF_MAX;
          slots_d   = '0;
          armed_d   = 1'b0;
          score_d   = '0;
          misses_d  = '0;
          retired_d = '0;
        end
      end

      ST_RUN: begin
        // The end condition is checked on registered counts, so the game
        // stops one cycle after the last retire/miss and nothing else moves.
        if ((retired_q == RETIRE_END) || (misses_q == MISS_END)) begin
          state_d = ST_OVER;
        end else begin
          tick   = (div_q == DIV_LAST);
          div_d  = tick ? '0 : div_q + DW'(1);
          hit_ok = hit && (slots_q[4:0] != EMPTY) && armed_q;

          if (hit_ok) begin
            armed_d = 1'b0;
            if (score_q != 8'hFF) begin
              score_d = score_q + 8'd1;
            end
          end

          if (tick) begin
            if (xoff_q != 9'd0) begin
              xoff_d = xoff_q - 9'd1;
            end else begin
              xoff_d  = XOFF_MAX;
              shift   = 1'b1;
              slots_d = {note_code(lfsr_state[1:0]), slots_q[24:5]};
              // The incoming slot-0 note is armed even if a hit landed on
              // the outgoing note in this same cycle.
              armed_d = 1'b1;
              if (slots_q[4:0] != EMPTY) begin
                retired_d = retired_q + RW'(1);
                if (armed_q && !hit_ok && (misses_q != 4'hF)) begin
                  misses_d = misses_q + 4'd1;
                end
              end
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_OVER);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      xoff_q    <= XOFF_MAX;
      slots_q   <= '0;
      armed_q   <= 1'b0;
      score_q   <= '0;
      misses_q  <= '0;
      retired_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      xoff_q    <= xoff_d;
      slots_q   <= slots_d;
      armed_q   <= armed_d;
      score_q   <= score_d;
      misses_q  <= misses_d;
      retired_q <= retired_d;
      done_q    <= done_d;
    end
  end

  assign xoffset    = xoff_q;
  assign drawstream = slots_q;
  assign target     = slots_q[1:0];
  assign score      = score_q;
  assign misses     = misses_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_note_scroller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_note_scroller
//  Purpose  : Self-checking bench for note_scroller. A behavioural game model
//             tracks the expected outputs every cycle under directed and
//             random stimulus; a second instance exercises score saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_note_scroller;

  localparam int          TD   = 2;
  localparam int          NPG  = 4;
  localparam int          MM   = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic        reset = 1'b1, start = 1'b0, hit = 1'b0;
  logic [8:0]  xoffset;
  logic [24:0] drawstream;
  logic [1:0]  target;
  logic [7:0]  score;
  logic [3:0]  misses;
  logic        done;

  note_scroller #(
    .TICK_DIV(TD), .NOTES_PER_GAME(NPG), .MAX_MISS(MM), .SEED(SEED)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .hit(hit),
    .xoffset(xoffset), .drawstream(drawstream), .target(target),
    .score(score), .misses(misses), .done(done)
  );

  // Saturation instance: long game, tick every cycle
  logic        reset2 = 1'b1, start2 = 1'b0, hit2 = 1'b0;
  logic [8:0]  x2_unused;
  logic [24:0] ds2_unused;
  logic [1:0]  tg2_unused;
  logic [7:0]  score2;
  logic [3:0]  misses2;
  logic        done2;
  logic        dut2_finished = 1'b0;

  note_scroller #(
    .TICK_DIV(1), .NOTES_PER_GAME(270), .MAX_MISS(15), .SEED(SEED)
  ) dut2 (
    .CLOCK_50(clk), .reset(reset2), .start(start2), .hit(hit2),
    .xoffset(x2_unused), .drawstream(ds2_unused), .target(tg2_unused),
    .score(score2), .misses(misses2), .done(done2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural game model ----------------
  int m_phase;      // 0 idle, 1 running, 2 over
  int m_cnt;        // cycles since last tick
  int m_x;
  int m_slot[5];    // m_slot[0] is the note at the hit line
  int m_armed;
  int m_score, m_miss, m_retired;
  int m_lfsr;

  function automatic int lfsr_next(input int l);
    int fb;
    fb = $countones(l & 32'h0000B400) & 1;
    return ((l << 1) | fb) & 32'h0000FFFF;
  endfunction

  function automatic logic game_ending();
    return (m_retired == NPG) || (m_miss == MM);
  endfunction

  function automatic logic shift_next();
    return (m_phase == 1) && !game_ending() && (m_x == 0) && (m_cnt == TD - 1);
  endfunction

  task automatic model_new_game();
    m_cnt = 0; m_x = 47; m_armed = 0;
    m_score = 0; m_miss = 0; m_retired = 0;
    for (int i = 0; i < 5; i++) m_slot[i] = 0;
  endtask

  task automatic model_step();
    int outgoing;
    logic accepted;
    if (reset) begin
      model_new_game();
      m_phase = 0;
      m_lfsr  = SEED;
    end else if (m_phase != 1) begin
      if (start) begin
        model_new_game();
        m_phase = 1;
      end
    end else if (game_ending()) begin
      m_phase = 2;
    end else begin
      accepted = hit && (m_slot[0] != 0) && (m_armed != 0);
      if (accepted) begin
        m_armed = 0;
        m_score = (m_score < 255) ? m_score + 1 : 255;
      end
      if (m_cnt == TD - 1) begin
        m_cnt = 0;
        if (m_x > 0) begin
          m_x--;
        end else begin
          m_x = 47;
          outgoing = m_slot[0];
          for (int i = 0; i < 4; i++) m_slot[i] = m_slot[i+1];
          m_slot[4] = 8 + (m_lfsr % 4);
          m_lfsr = lfsr_next(m_lfsr);
          if (outgoing != 0) begin
            m_retired++;
            if (m_armed != 0) m_miss = (m_miss < 15) ? m_miss + 1 : 15;
          end
          m_armed = 1;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic compare_all();
    int ds;
    ds = 0;
    for (int i = 0; i < 5; i++) ds = ds | (m_slot[i] << (5 * i));
    check("xoffset",    32'(xoffset),    32'(m_x));
    check("drawstream", 32'(drawstream), 32'(ds));
    check("target",     32'(target),     32'(m_slot[0] % 4));
    check("score",      32'(score),      32'(m_score));
    check("misses",     32'(misses),     32'(m_miss));
    check("done",       32'(done),       32'(m_phase == 2));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // Run until the next clock edge will shift the slots (bounded).
  task automatic wait_shift(input int max_cycles);
    int k;
    logic timed_out;
    k = 0;
    while (!shift_next() && k < max_cycles) begin
      step();
      k++;
    end
    timed_out = !shift_next();
    check("wait_shift_timeout", 32'(timed_out), 32'd0);
  endtask

  // ---------------- main instance stimulus ----------------
  initial begin
    int k;
    int rate;
    m_phase = 0;
    m_lfsr  = SEED;
    model_new_game();

    @(negedge clk);
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_xoffset",    32'(xoffset),    32'd47);
    check("rst_drawstream", 32'(drawstream), 32'd0);
    check("rst_target",     32'(target),     32'd0);
    check("rst_score",      32'(score),      32'd0);
    check("rst_misses",     32'(misses),     32'd0);
    check("rst_done",       32'(done),       32'd0);

    // First game: tick timing, first shift, hits
    start = 1'b1; step(); start = 1'b0;
    check("start_xoffset", 32'(xoffset), 32'd47);
    step(); step();
    check("tick_xoffset", 32'(xoffset), 32'd46);
    repeat (94) step();
    check("first_shift_slot4", 32'(drawstream[24:20]), 32'h09);
    check("first_shift_x",     32'(xoffset),           32'd47);

    repeat (4) begin wait_shift(200); step(); end
    repeat (3) step();
    hit = 1'b1; step(); hit = 1'b0;
    check("hit_score", 32'(score), 32'd1);
    repeat (3) step();
    hit = 1'b1; step(); hit = 1'b0;
    check("rehit_score", 32'(score), 32'd1);

    wait_shift(200); step();
    check("hit_note_no_miss", 32'(misses), 32'd0);

    wait_shift(200);
    hit = 1'b1; step(); hit = 1'b0;
    check("coinc_score",  32'(score),  32'd2);
    check("coinc_misses", 32'(misses), 32'd0);
    step();
    hit = 1'b1; step(); hit = 1'b0;
    check("coinc_new_armed", 32'(score), 32'd3);

    k = 0;
    while (!done && k < 1000) begin step(); k++; end
    check("game1_done",   32'(done),   32'd1);
    check("game1_score",  32'(score),  32'd3);
    check("game1_misses", 32'(misses), 32'd1);

    // Second game: no hits, two misses end it
    start = 1'b1; step(); start = 1'b0;
    check("restart_score",      32'(score),      32'd0);
    check("restart_drawstream", 32'(drawstream), 32'd0);
    repeat (7) begin wait_shift(200); step(); end
    check("nohit_misses",   32'(misses), 32'd2);
    check("nohit_done_pre", 32'(done),   32'd0);
    step();
    check("nohit_done", 32'(done),    32'd1);
    check("over_x",     32'(xoffset), 32'd47);
    repeat (10) step();
    check("frozen_x",      32'(xoffset), 32'd47);
    check("frozen_misses", 32'(misses),  32'd2);

    // Third game: reset mid-run with score 3
    start = 1'b1; step(); start = 1'b0;
    hit = 1'b1;
    k = 0;
    while (m_score < 3 && k < 3000) begin step(); k++; end
    check("pre_rst_score", 32'(score), 32'd3);
    reset = 1'b1; step(); reset = 1'b0; hit = 1'b0;
    check("midrst_score",   32'(score),   32'd0);
    check("midrst_done",    32'(done),    32'd0);
    check("midrst_xoffset", 32'(xoffset), 32'd47);
    repeat (4) step();
    check("idle_hold_x", 32'(xoffset), 32'd47);

    // Random play
    rate = 30;
    for (int c = 0; c < 9000; c++) begin
      if (c % 800 == 0) begin
        case ($urandom_range(0, 3))
          0:       rate = 2;
          1:       rate = 30;
          2:       rate = 150;
          default: rate = 100000;
        endcase
      end
      reset = ($urandom_range(0, 2999) == 0);
      start = (m_phase != 1) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 299) == 0);
      hit   = ($urandom_range(0, rate - 1) == 0);
      step();
    end
    reset = 1'b0; start = 1'b0; hit = 1'b0;

    k = 0;
    while (!dut2_finished && k < 40000) begin @(negedge clk); k++; end
    check("sat_finished", 32'(dut2_finished), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- saturation instance stimulus ----------------
  // 270 notes all hit: score must hold at 255 rather than wrap.
  initial begin
    int k;
    @(negedge clk); @(negedge clk);
    reset2 = 1'b0;
    check("sat_rst_score", 32'(score2), 32'd0);
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    hit2 = 1'b1;
    k = 0;
    while (!done2 && k < 20000) begin @(negedge clk); k++; end
    hit2 = 1'b0;
    check("sat_done",   32'(done2),   32'd1);
    check("sat_score",  32'(score2),  32'd255);
    check("sat_misses", 32'(misses2), 32'd0);
    dut2_finished = 1'b1;
  end

endmodule
`default_nettype wire
